// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, Bit_number
// codes and the fallback prescale used when the latched value is below 2.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic [3:0] BitNumStart  = 4'd0;
    localparam logic [3:0] BitNumParity = 4'd9;
    localparam logic [3:0] BitNumStop   = 4'd10;

    localparam int unsigned DefaultPrescale = 8;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: Bit_Counter runs 1..limit and strobes bit_done_o on the
// last cycle of each bit period.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_done_o
);

    logic [PRESCALE_W-1:0] bit_counter_d, bit_counter_q;
    logic [PRESCALE_W-1:0] limit;

    // Prescale values 0 and 1 cannot form a sensible bit period.
    assign limit      = (prescale_i < PRESCALE_W'(2)) ? PRESCALE_W'(DefaultPrescale) : prescale_i;
    assign bit_done_o = run_i && (bit_counter_q == limit);

    always_comb begin
        bit_counter_d = bit_counter_q;
        if (load_i) begin
            bit_counter_d = PRESCALE_W'(1);
        end else if (run_i) begin
            bit_counter_d = bit_done_o ? PRESCALE_W'(1) : bit_counter_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_counter_q <= '0;
        end else begin
            bit_counter_q <= bit_counter_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start, 8 data bits LSB-first, optional parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [7:0]            P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Done,
    output logic [3:0]            Bit_number
);

    tx_state_e             state_d, state_q;
    logic [7:0]            data_d, data_q;
    logic [PRESCALE_W-1:0] prescale_d, prescale_q;
    logic [3:0]            bit_num_d, bit_num_q;
    logic                  tx_d, tx_q;
    logic                  done_d, done_q;
    logic                  timer_load;
    logic                  bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_d, par_en_q;
    logic par_bit_d, par_bit_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    assign Busy       = (state_q != StIdle);
    assign TX_OUT     = tx_q;
    assign Done       = done_q;
    assign Bit_number = bit_num_q;

    uart_tx_bit_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_bit_timer (
        .clk_i     (CLK),
        .rst_ni    (RSTn),
        .load_i    (timer_load),
        .run_i     (Busy),
        .prescale_i(prescale_q),
        .bit_done_o(bit_done)
    );

    // tx_d always holds the level for the next cycle, so TX_OUT comes straight off a flop.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        prescale_d = prescale_q;
        bit_num_d  = bit_num_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (Data_Valid) begin
                    data_d     = P_DATA;
                    prescale_d = PRESCALE;
                    bit_num_d  = BitNumStart;
                    tx_d       = 1'b0;
                    timer_load = 1'b1;
                    state_d    = StStart;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = PAR_EN;
                    par_bit_d  = (^P_DATA) ^ PAR_TYP;
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_num_d = 4'd1;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_num_q == 4'd8) begin
                        state_d   = StStop;
                        bit_num_d = BitNumStop;
                        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d   = StParity;
                            bit_num_d = BitNumParity;
                            tx_d      = par_bit_q;
                        end
`endif
                    end else begin
                        // Bit_number k carries data[k-1], so the next bit is data[bit_num_q].
                        bit_num_d = bit_num_q + 4'd1;
                        tx_d      = data_q[bit_num_q[2:0]];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d   = StStop;
                    bit_num_d = BitNumStop;
                    tx_d      = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    state_d   = StIdle;
                    bit_num_d = BitNumStart;
                    tx_d      = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            data_q     <= '0;
            prescale_q <= '0;
            bit_num_q  <= BitNumStart;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            prescale_q <= prescale_d;
            bit_num_q  <= bit_num_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

endmodule
